quad_decoder: RTL and testbench

Quadrature decoder that converts two-phase encoder signals (A/B) into single-cycle step pulses, a direction flag and a wrapping position count. It is the producer side of the team's up/down counting path: step/dir drive a counter's enable and up/down controls. The block also keeps an internal POS_W-bit position register. Inputs are asynchronous pins, so the block synchronises and glitch-filters them before decoding.

---
 rtl/quad_decoder_if.sv | 32 +++
 rtl/quad_decoder.sv | 117 +++++++++++
 tb/tb_quad_decoder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/quad_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : quad_decoder_if
// Brief    : Control, encoder-pin and step/position signals of the quadrature
//            decoder. The master drives the controls and encoder pins; the
//            decoder (slave) produces step/dir/position/err.
// Revision : 1.0 - initial release
// ============================================================================
interface quad_decoder_if #(
  parameter int POS_W = 16
);
  logic             enable;
  logic             clear;
  logic             err_clr;
  logic             quad_a;
  logic             quad_b;
  logic             step;
  logic             dir;
  logic [POS_W-1:0] position;
  logic             err;

  modport master (
    output enable, clear, err_clr, quad_a, quad_b,
    input  step, dir, position, err
  );

  modport slave (
    input  enable, clear, err_clr, quad_a, quad_b,
    output step, dir, position, err
  );
endinterface
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quad_decoder
// Brief    : Quadrature decoder. Synchronises and glitch-filters the A/B
//            encoder pins, then emits one-cycle step pulses, a direction flag,
//            a wrapping position count and a sticky illegal-transition flag.
// Revision : 1.0 - initial release
// ============================================================================
module quad_decoder #(
  parameter int POS_W    = 16,
  parameter int FILT_LEN = 3
) (
  input wire clk,
  input wire reset,
  quad_decoder_if.slave bus
);

  localparam int               CNT_W    = $clog2(FILT_LEN + 1);
  // Counter value seen on the edge just before the FILT_LEN-th mismatch.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  // Bit 1 is phase A, bit 0 is phase B, so filt is directly the state {A,B}.
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] filt;
  logic [1:0] prev_s;

  logic       up;
  logic       down;
  logic       illegal;
  logic       legal_en;

  assign raw = {bus.quad_a, bus.quad_b};

  // Two-flop synchroniser for both encoder pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  generate
    for (genvar ch = 0; ch < 2; ch++) begin : g_filt
      logic [CNT_W-1:0] cnt;
      logic             level;

      assign filt[ch] = level;

      // Accept a new level only after FILT_LEN consecutive disagreeing edges.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt   <= '0;
          level <= 1'b0;
        end else if (sync2[ch] == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level <= sync2[ch];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

  // Classify the filtered state change against the Gray up/down sequence.
  always_comb begin
    up      = 1'b0;
    down    = 1'b0;
    illegal = 1'b0;
    case ({prev_s, filt})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: up      = 1'b1;
      4'b1000, 4'b1110, 4'b0111, 4'b0001: down    = 1'b1;
      4'b0011, 4'b1100, 4'b1001, 4'b0110: illegal = 1'b1;
      default: ;
    endcase
  end

  assign legal_en = bus.enable & (up | down);

  // Registered step/dir/position/err; prev_s tracks even while disabled so
  // that re-enabling never produces a catch-up step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_s       <= 2'b00;
      bus.step     <= 1'b0;
      bus.dir      <= 1'b1;
      bus.position <= '0;
      bus.err      <= 1'b0;
    end else begin
      prev_s   <= filt;
      bus.step <= legal_en;
      if (legal_en) begin
        bus.dir <= up;
      end
      if (bus.clear) begin
        bus.position <= '0;
      end else if (bus.enable && up) begin
        bus.position <= bus.position + 1'b1;
      end else if (bus.enable && down) begin
        bus.position <= bus.position - 1'b1;
      end
      if (bus.enable && illegal) begin
        bus.err <= 1'b1;
      end else if (bus.err_clr) begin
        bus.err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_decoder
// Brief    : Self-checking bench for quad_decoder: table of input phases with
//            expected outputs, plus a step scoreboard and corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_decoder;

  localparam int POS_W    = 16;
  localparam int FILT_LEN = 3;
  localparam int HOLD     = 8;
  localparam int LAT      = FILT_LEN + 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  quad_decoder_if #(.POS_W(POS_W)) bus ();

  quad_decoder #(
    .POS_W   (POS_W),
    .FILT_LEN(FILT_LEN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             en;
    logic             a;
    logic             b;
    logic             clr;
    logic             step;
    logic             dir;
    logic [POS_W-1:0] pos;
    logic             err;
  } vec_t;

  vec_t             tbl[22];
  logic [POS_W:0]   sb_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;

  function automatic vec_t row(input logic en, a, b, clr, step, dir,
                               input logic [POS_W-1:0] pos, input logic err);
    vec_t v;
    v.en = en; v.a = a; v.b = b; v.clr = clr;
    v.step = step; v.dir = dir; v.pos = pos; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every step pulse must match the next queued {dir, position}.
  always @(negedge clk) begin
    if (!reset && bus.step === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_step", 32'(bus.position), 32'hDEAD);
      end else begin
        logic [POS_W:0] e;
        e = sb_q.pop_front();
        check("sb_dir", 32'(bus.dir), 32'(e[POS_W]));
        check("sb_position", 32'(bus.position), 32'(e[POS_W-1:0]));
      end
    end
  end

  // Drive one phase and hold it HOLD cycles; optional clear / err_clr pulse
  // lands exactly on the edge where the decode of this change happens.
  task automatic apply_row(input vec_t v, input bit clr_at_dec, input bit eclr_at_dec);
    int nsteps;
    int first;
    nsteps = 0;
    first  = -1;
    @(negedge clk);
    bus.enable = v.en;
    bus.quad_a = v.a;
    bus.quad_b = v.b;
    bus.clear  = v.clr;
    if (v.step) sb_q.push_back({v.dir, v.pos});
    for (int i = 0; i < HOLD; i++) begin
      @(posedge clk);
      #1;
      bus.clear   = (i == LAT - 1) && clr_at_dec;
      bus.err_clr = (i == LAT - 1) && eclr_at_dec;
      if (bus.step === 1'b1) begin
        if (first < 0) first = i;
        nsteps++;
      end
    end
    check("step_count", nsteps, 32'(v.step));
    if (v.step) check("step_latency", first, LAT);
    check("dir", 32'(bus.dir), 32'(v.dir));
    check("position", 32'(bus.position), 32'(v.pos));
    check("err", 32'(bus.err), 32'(v.err));
  endtask

  task automatic count_steps(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.step === 1'b1) cnt++;
    end
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("err_after_clr", 32'(bus.err), 0);
  endtask

  initial begin
    int         cnt;
    logic [1:0] seq[4];
    logic [1:0] s;

    //            en    a     b     clr   step  dir   pos            err
    tbl[0]  = row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    tbl[1]  = row(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0);
    tbl[2]  = row(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0);
    tbl[3]  = row(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0);
    tbl[4]  = row(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 1'b0);
    tbl[5]  = row(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
    tbl[6]  = row(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0);
    tbl[7]  = row(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0);
    tbl[8]  = row(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFD, 1'b0);
    tbl[9]  = row(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFC, 1'b0);
    tbl[10] = row(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFC, 1'b0);
    tbl[11] = row(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFC, 1'b0);
    tbl[12] = row(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFC, 1'b0);
    tbl[13] = row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFC, 1'b0);
    tbl[14] = row(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFC, 1'b0);
    tbl[15] = row(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFC, 1'b0);
    tbl[16] = row(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFD, 1'b0);
    tbl[17] = row(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    tbl[18] = row(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
    tbl[19] = row(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
    tbl[20] = row(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0);
    tbl[21] = row(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0);

    bus.enable  = 1'b1;
    bus.clear   = 1'b0;
    bus.err_clr = 1'b0;
    bus.quad_a  = 1'b0;
    bus.quad_b  = 1'b0;

    // Reset state, checked while reset is held.
    #1 reset = 1'b1;
    #1;
    check("rst_step", 32'(bus.step), 0);
    check("rst_dir", 32'(bus.dir), 1);
    check("rst_position", 32'(bus.position), 0);
    check("rst_err", 32'(bus.err), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) apply_row(tbl[i], 1'b0, 1'b0);

    // Back to 00: position 3, dir up.
    apply_row(row(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0), 1'b0, 1'b0);

    // Glitch rejection: 2-cycle pulse dropped, 3-cycle pulse gives up then down.
    @(negedge clk);
    bus.quad_a = 1'b1;
    repeat (2) @(negedge clk);
    bus.quad_a = 1'b0;
    count_steps(12, cnt);
    check("glitch2_steps", cnt, 0);
    check("glitch2_position", 32'(bus.position), 32'h3);
    sb_q.push_back({1'b1, 16'h0004});
    sb_q.push_back({1'b0, 16'h0003});
    @(negedge clk);
    bus.quad_a = 1'b1;
    repeat (3) @(negedge clk);
    bus.quad_a = 1'b0;
    count_steps(14, cnt);
    check("glitch3_steps", cnt, 2);
    check("glitch3_position", 32'(bus.position), 32'h3);
    check("glitch3_dir", 32'(bus.dir), 0);

    // Illegal jump 00 -> 11 sets err; err_clr alone clears it.
    apply_row(row(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1), 1'b0, 1'b0);
    pulse_err_clr();
    // Illegal jump 11 -> 00 with err_clr on the same edge: set wins.
    apply_row(row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1), 1'b0, 1'b1);
    pulse_err_clr();

    // Clear coincident with an up step: position 0, step and dir still update.
    apply_row(row(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0), 1'b1, 1'b0);

    // Seven up steps from state 10 to reach position 7 at state 00.
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    for (int i = 1; i <= 7; i++) begin
      s = seq[i % 4];
      apply_row(row(1'b1, s[1], s[0], 1'b0, 1'b1, 1'b1, 16'(i), 1'b0), 1'b0, 1'b0);
    end

    // Asynchronous reset mid-count, observed before the next clock edge.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_position", 32'(bus.position), 0);
    check("async_rst_step", 32'(bus.step), 0);
    check("async_rst_dir", 32'(bus.dir), 1);
    check("async_rst_err", 32'(bus.err), 0);
    @(negedge clk);
    reset = 1'b0;
    apply_row(row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0), 1'b0, 1'b0);

    check("sb_leftover", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
